// File: rtl/parking_lot_top.sv
// Multi-storey parking controller: one elevator, seven floors of two slots,
// per-slot fee timers and flood lockout of leaking floors.
module parking_lot_top #(
    parameter logic [7:0] FEE_PER_CYCLE = 8'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] license_plate,
    input  logic        in_mode,
    input  logic        out_mode,
    input  logic        leakage,
    input  logic [2:0]  leakage_floor,
    output logic [31:0] parked_1,
    output logic [31:0] parked_2,
    output logic [31:0] parked_3,
    output logic [31:0] parked_4,
    output logic [31:0] parked_5,
    output logic [31:0] parked_6,
    output logic [31:0] parked_7,
    output logic [2:0]  current_floor,
    output logic [15:0] moving,
    output logic        plate_type,
    output logic [7:0]  fee,
    output logic        empty_suv,
    output logic        empty_sedan,
    output logic        full_suv,
    output logic        full_sedan
);

    typedef enum logic [2:0] {
        IDLE,
        UP_IN,
        STORE,
        UP_OUT,
        LOAD,
        DOWN,
        EXIT
    } state_t;

    state_t r_state;
    state_t w_next;

    // slot i sits on floor i/2+1; even i is slot A, odd i is slot B
    logic [13:0][15:0] r_plate;
    logic [13:0][7:0]  r_timer;
    logic [7:1]        r_flood;

    logic [2:0]  r_floor;
    logic [2:0]  r_target;
    logic [3:0]  r_idx;
    logic [15:0] r_moving;
    logic        r_type;
    logic        r_is_out;
    logic [7:0]  r_fee;
    logic [7:0]  r_fee_cap;
    logic        r_empty_suv;
    logic        r_empty_sedan;
    logic        r_full_suv;
    logic        r_full_sedan;

    logic [13:0] w_slot_flood;
    logic        w_is_suv;
    logic        w_req_ok;
    logic        w_free_hit;
    logic [3:0]  w_free_idx;
    logic        w_find_hit;
    logic [3:0]  w_find_idx;
    logic        w_park_ok;
    logic        w_fetch_ok;
    logic [2:0]  w_free_floor;
    logic [2:0]  w_find_floor;
    logic        w_any_suv;
    logic        w_any_sedan;
    logic        w_free_suv;
    logic        w_free_sedan;

    function automatic logic [7:0] sat_add(input logic [7:0] a);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, FEE_PER_CYCLE};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign w_slot_flood = {
        {2{r_flood[7]}}, {2{r_flood[6]}}, {2{r_flood[5]}},
        {2{r_flood[4]}}, {2{r_flood[3]}}, {2{r_flood[2]}},
        {2{r_flood[1]}}
    };

    assign w_is_suv = license_plate[0];
    assign w_req_ok = (license_plate != 16'h0000);

    // first free dry slot of the plate's class, and any slot holding the plate
    always_comb begin
        w_free_hit = 1'b0;
        w_free_idx = 4'd0;
        w_find_hit = 1'b0;
        w_find_idx = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (!w_find_hit && r_plate[i] == license_plate) begin
                w_find_hit = 1'b1;
                w_find_idx = 4'(i);
            end
            if (!w_free_hit && ((i < 6) == w_is_suv) &&
                r_plate[i] == 16'h0000 && !w_slot_flood[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = 4'(i);
            end
        end
    end

    assign w_free_floor = w_free_idx[3:1] + 3'd1;
    assign w_find_floor = w_find_idx[3:1] + 3'd1;

    assign w_park_ok  = w_req_ok && in_mode && w_free_hit && !w_find_hit;
    assign w_fetch_ok = w_req_ok && !in_mode && out_mode && w_find_hit;

    always_comb begin
        w_any_suv    = 1'b0;
        w_any_sedan  = 1'b0;
        w_free_suv   = 1'b0;
        w_free_sedan = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (r_plate[i] != 16'h0000) begin
                if (i < 6) w_any_suv = 1'b1;
                else       w_any_sedan = 1'b1;
            end else if (!w_slot_flood[i]) begin
                if (i < 6) w_free_suv = 1'b1;
                else       w_free_sedan = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_park_ok)       w_next = UP_IN;
                else if (w_fetch_ok) w_next = UP_OUT;
            end
            UP_IN: begin
                if (r_floor + 3'd1 == r_target) w_next = STORE;
            end
            UP_OUT: begin
                if (r_floor + 3'd1 == r_target) w_next = LOAD;
            end
            STORE:   w_next = DOWN;
            LOAD:    w_next = DOWN;
            DOWN: begin
                if (r_floor == 3'd1) begin
                    if (r_is_out) w_next = EXIT;
                    else          w_next = IDLE;
                end
            end
            EXIT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_plate       <= '0;
            r_timer       <= '0;
            r_flood       <= '0;
            r_floor       <= 3'd0;
            r_target      <= 3'd0;
            r_idx         <= 4'd0;
            r_moving      <= 16'h0000;
            r_type        <= 1'b0;
            r_is_out      <= 1'b0;
            r_fee         <= 8'd0;
            r_fee_cap     <= 8'd0;
            r_empty_suv   <= 1'b1;
            r_empty_sedan <= 1'b1;
            r_full_suv    <= 1'b0;
            r_full_sedan  <= 1'b0;
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (r_plate[i] != 16'h0000)
                    r_timer[i] <= sat_add(r_timer[i]);
            end
            if (leakage && leakage_floor != 3'd0)
                r_flood[leakage_floor] <= 1'b1;

            r_empty_suv   <= !w_any_suv;
            r_empty_sedan <= !w_any_sedan;
            r_full_suv    <= !w_free_suv;
            r_full_sedan  <= !w_free_sedan;

            case (r_state)
                IDLE: begin
                    if (w_park_ok) begin
                        r_moving <= license_plate;
                        r_type   <= w_is_suv;
                        r_target <= w_free_floor;
                        r_idx    <= w_free_idx;
                        r_is_out <= 1'b0;
                    end else if (w_fetch_ok) begin
                        r_type   <= w_is_suv;
                        r_target <= w_find_floor;
                        r_idx    <= w_find_idx;
                        r_is_out <= 1'b1;
                    end
                end
                UP_IN, UP_OUT: r_floor <= r_floor + 3'd1;
                STORE: begin
                    r_plate[r_idx] <= r_moving;
                    r_timer[r_idx] <= 8'd0;
                    r_moving       <= 16'h0000;
                end
                LOAD: begin
                    r_moving       <= r_plate[r_idx];
                    r_plate[r_idx] <= 16'h0000;
                    r_fee_cap      <= r_timer[r_idx];
                end
                DOWN: r_floor <= r_floor - 3'd1;
                EXIT: begin
                    r_moving <= 16'h0000;
                    r_fee    <= r_fee_cap;
                end
                default: ;
            endcase
        end
    end

    assign parked_1      = {r_plate[0],  r_plate[1]};
    assign parked_2      = {r_plate[2],  r_plate[3]};
    assign parked_3      = {r_plate[4],  r_plate[5]};
    assign parked_4      = {r_plate[6],  r_plate[7]};
    assign parked_5      = {r_plate[8],  r_plate[9]};
    assign parked_6      = {r_plate[10], r_plate[11]};
    assign parked_7      = {r_plate[12], r_plate[13]};
    assign current_floor = r_floor;
    assign moving        = r_moving;
    assign plate_type    = r_type;
    assign fee           = r_fee;
    assign empty_suv     = r_empty_suv;
    assign empty_sedan   = r_empty_sedan;
    assign full_suv      = r_full_suv;
    assign full_sedan    = r_full_sedan;

endmodule

// File: tb/tb_parking_lot_top.sv
// Bench for parking_lot_top: trip-time reference model checked every cycle,
// directed scenarios with literal pins, then randomized traffic.
module tb_parking_lot_top;

    localparam logic [7:0] FEE = 8'd1;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] license_plate;
    logic        in_mode, out_mode, leakage;
    logic [2:0]  leakage_floor;
    logic [31:0] parked_1, parked_2, parked_3, parked_4;
    logic [31:0] parked_5, parked_6, parked_7;
    logic [2:0]  current_floor;
    logic [15:0] moving;
    logic        plate_type;
    logic [7:0]  fee;
    logic        empty_suv, empty_sedan, full_suv, full_sedan;

    parking_lot_top #(.FEE_PER_CYCLE(FEE)) dut (
        .clock(clock), .reset(reset),
        .license_plate(license_plate),
        .in_mode(in_mode), .out_mode(out_mode),
        .leakage(leakage), .leakage_floor(leakage_floor),
        .parked_1(parked_1), .parked_2(parked_2),
        .parked_3(parked_3), .parked_4(parked_4),
        .parked_5(parked_5), .parked_6(parked_6),
        .parked_7(parked_7),
        .current_floor(current_floor), .moving(moving),
        .plate_type(plate_type), .fee(fee),
        .empty_suv(empty_suv), .empty_sedan(empty_sedan),
        .full_suv(full_suv), .full_sedan(full_sedan)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    // garage as the spec describes it: plates by floor/slot
    logic [15:0] m_slot [1:7][0:1];
    int unsigned m_tin  [1:7][0:1];
    bit          m_flood [1:7];
    bit          m_valid = 0;
    bit          m_busy, m_out;
    int          m_t, m_T, m_fl, m_sl;
    logic [15:0] m_plate;
    logic [7:0]  m_fee_pend;
    logic [2:0]  e_floor;
    logic [15:0] e_moving;
    logic        e_type;
    logic [7:0]  e_fee;
    logic        e_es, e_ed, e_fs, e_fd;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] fee_of(input int unsigned n);
        longint v;
        v = longint'(n) * longint'(FEE);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

    task automatic model_reset();
        for (int f = 1; f <= 7; f++) begin
            m_flood[f] = 0;
            for (int k = 0; k < 2; k++) begin
                m_slot[f][k] = 16'h0;
                m_tin[f][k]  = 0;
            end
        end
        m_busy = 0; m_out = 0; m_t = 0; m_T = 0;
        m_fee_pend = 8'd0;
        e_floor = 3'd0; e_moving = 16'h0; e_type = 0; e_fee = 8'd0;
        e_es = 1; e_ed = 1; e_fs = 0; e_fd = 0;
        m_valid = 1;
    endtask

    task automatic start_trip(input bit out, input logic [15:0] p,
                              input int f, input int s);
        m_busy = 1; m_out = out; m_t = 0; m_T = f;
        m_fl = f; m_sl = s; m_plate = p; e_type = p[0];
        if (!out) e_moving = p;
    endtask

    task automatic model_edge();
        bit nes, ned, nfs, nfd, hit, dup, suv;
        int f, s, lo, hi;
        logic [15:0] p;
        nes = 1; ned = 1; nfs = 1; nfd = 1;
        for (int fl = 1; fl <= 7; fl++)
            for (int k = 0; k < 2; k++) begin
                if (m_slot[fl][k] != 16'h0) begin
                    if (fl <= 3) nes = 0; else ned = 0;
                end else if (!m_flood[fl]) begin
                    if (fl <= 3) nfs = 0; else nfd = 0;
                end
            end
        if (m_busy) begin
            m_t++;
            if (m_t <= m_T) begin
                e_floor = 3'(m_t);
            end else if (m_t == m_T + 1) begin
                if (!m_out) begin
                    m_slot[m_fl][m_sl] = m_plate;
                    m_tin[m_fl][m_sl]  = cyc;
                    e_moving = 16'h0;
                end else begin
                    e_moving = m_plate;
                    m_fee_pend = fee_of(cyc - m_tin[m_fl][m_sl] - 1);
                    m_slot[m_fl][m_sl] = 16'h0;
                end
            end else if (m_t <= 2 * m_T + 1) begin
                e_floor = 3'(2 * m_T + 1 - m_t);
                if (m_t == 2 * m_T + 1 && !m_out) m_busy = 0;
            end else begin
                e_moving = 16'h0;
                e_fee = m_fee_pend;
                m_busy = 0;
            end
        end else if (license_plate != 16'h0) begin
            p = license_plate;
            suv = p[0];
            dup = 0; f = 0; s = 0;
            for (int fl = 1; fl <= 7; fl++)
                for (int k = 0; k < 2; k++)
                    if (!dup && m_slot[fl][k] == p) begin
                        dup = 1; f = fl; s = k;
                    end
            if (in_mode) begin
                lo = suv ? 1 : 4;
                hi = suv ? 3 : 7;
                hit = 0;
                for (int fl = lo; fl <= hi; fl++)
                    for (int k = 0; k < 2; k++)
                        if (!hit && !m_flood[fl] && m_slot[fl][k] == 16'h0) begin
                            hit = 1; f = fl; s = k;
                        end
                if (hit && !dup) start_trip(0, p, f, s);
            end else if (out_mode && dup) begin
                start_trip(1, p, f, s);
            end
        end
        if (leakage && leakage_floor != 3'd0) m_flood[leakage_floor] = 1;
        e_es = nes; e_ed = ned; e_fs = nfs; e_fd = nfd;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (!reset)       model_reset();
            else if (m_valid) model_edge();
        end
    end

    // every cycle: all outputs against the model
    initial begin
        logic [31:0] act_p [1:7];
        forever begin
            @(negedge clock);
            if (m_valid) begin
                act_p[1] = parked_1; act_p[2] = parked_2;
                act_p[3] = parked_3; act_p[4] = parked_4;
                act_p[5] = parked_5; act_p[6] = parked_6;
                act_p[7] = parked_7;
                for (int f = 1; f <= 7; f++)
                    cmp($sformatf("parked_%0d", f), act_p[f],
                        {m_slot[f][0], m_slot[f][1]});
                cmp("current_floor", 32'(current_floor), 32'(e_floor));
                cmp("moving", 32'(moving), 32'(e_moving));
                cmp("plate_type", 32'(plate_type), 32'(e_type));
                cmp("fee", 32'(fee), 32'(e_fee));
                cmp("empty_suv", 32'(empty_suv), 32'(e_es));
                cmp("empty_sedan", 32'(empty_sedan), 32'(e_ed));
                cmp("full_suv", 32'(full_suv), 32'(e_fs));
                cmp("full_sedan", 32'(full_sedan), 32'(e_fd));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input logic [15:0] p, input bit i, input bit o);
        license_plate = p; in_mode = i; out_mode = o;
        @(negedge clock);
        license_plate = 16'h0; in_mode = 0; out_mode = 0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_busy && k < 60) begin
            @(negedge clock);
            k++;
        end
        if (m_busy) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: elevator busy after %0d cycles", k);
        end
    endtask

    logic [15:0] pool [16] = '{
        16'h8754, 16'h9423, 16'h1112, 16'h2468,
        16'h1235, 16'h3331, 16'h4447, 16'h5559,
        16'h7773, 16'h9999, 16'h1357, 16'h0246,
        16'h8080, 16'h6661, 16'h2224, 16'h5550
    };

    initial begin
        reset = 0; license_plate = 16'h0;
        in_mode = 0; out_mode = 0;
        leakage = 0; leakage_floor = 3'd0;
        step(2);
        cmp("rst_parked_4", parked_4, 32'h0);
        cmp("rst_floor", 32'(current_floor), 32'd0);
        cmp("rst_fee", 32'(fee), 32'd0);
        cmp("rst_empty_suv", 32'(empty_suv), 32'd1);
        cmp("rst_full_sedan", 32'(full_sedan), 32'd0);
        reset = 1;

        // sedan 8754 to floor 4, then straight back out
        drive(16'h8754, 1, 0);
        cmp("park_moving", 32'(moving), 32'h8754);
        cmp("park_type", 32'(plate_type), 32'd0);
        step(4);
        cmp("park_floor4", 32'(current_floor), 32'd4);
        step(1);
        cmp("park_slot", parked_4, 32'h8754_0000);
        cmp("park_moved0", 32'(moving), 32'h0);
        step(1);
        cmp("park_empty_sed", 32'(empty_sedan), 32'd0);
        step(3);
        cmp("park_home", 32'(current_floor), 32'd0);
        drive(16'h8754, 0, 1);
        step(5);
        cmp("ret_moving", 32'(moving), 32'h8754);
        cmp("ret_slot", parked_4, 32'h0);
        step(5);
        cmp("ret_fee", 32'(fee), 32'd9);
        cmp("ret_moving0", 32'(moving), 32'h0);
        cmp("ret_empty_sed", 32'(empty_sedan), 32'd1);

        // SUV 9423 to floor 1; a park pulse mid-trip is dropped
        drive(16'h9423, 1, 0);
        drive(16'h1235, 1, 0);
        cmp("suv_floor1", 32'(current_floor), 32'd1);
        step(1);
        cmp("suv_slot", parked_1, 32'h9423_0000);
        wait_idle();

        // flooded floor 4 keeps its car but takes no new ones
        drive(16'h2468, 1, 0);
        wait_idle();
        leakage = 1; leakage_floor = 3'd4;
        step(1);
        leakage = 0; leakage_floor = 3'd0;
        drive(16'h1112, 1, 0);
        wait_idle();
        cmp("leak_p5", parked_5, 32'h1112_0000);
        cmp("leak_p4", parked_4, 32'h2468_0000);
        drive(16'h2468, 0, 1);
        wait_idle();
        cmp("leak_ret", parked_4, 32'h0);

        // fill all six SUV slots
        drive(16'h1235, 1, 0); wait_idle();
        drive(16'h3331, 1, 0); wait_idle();
        drive(16'h4447, 1, 0); wait_idle();
        drive(16'h5559, 1, 0); wait_idle();
        drive(16'h7773, 1, 0); wait_idle();
        step(2);
        cmp("full_suv", 32'(full_suv), 32'd1);
        cmp("full_p3", parked_3, 32'h5559_7773);
        drive(16'h9999, 1, 0);
        step(1);
        cmp("full_drop", 32'(current_floor), 32'd0);
        drive(16'h1357, 0, 1);
        step(1);
        cmp("absent_drop", 32'(current_floor), 32'd0);

        // long stay saturates the fee
        step(300);
        drive(16'h9423, 0, 1);
        wait_idle();
        cmp("fee_sat", 32'(fee), 32'hFF);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = ($urandom_range(0, 499) != 0);
            in_mode = (r < 25);
            out_mode = (r >= 15 && r < 50);
            license_plate = ($urandom_range(0, 19) == 0) ? 16'h0 :
                            pool[$urandom_range(0, 15)];
            leakage = ($urandom_range(0, 79) == 0);
            leakage_floor = 3'($urandom_range(0, 7));
            step(1);
        end
        reset = 1; in_mode = 0; out_mode = 0;
        license_plate = 16'h0; leakage = 0;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
